// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: access-size
//            encodings, the controller state enum and the alignment check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access-size encodings carried on req_size. Code 3 is reserved and
  // behaves exactly like SIZE_WORD everywhere it is decoded.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // A halfword must sit on an even byte, a word on a multiple of four.
  // Bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic r;
    case (size)
      SIZE_BYTE: r = 1'b0;
      SIZE_HALF: r = addr_lo[0];
      default:   r = (addr_lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Bundles the core-side request/response handshake and the
//            word-addressed data-memory bus of the load/store unit.
// Ports    : none (signals only)
//            master - environment side (core + memory): drives requests and
//                     mem_data_out, observes responses and memory strobes.
//            slave  - the load/store unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [31:0]           mem_address;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_write_en, mem_read_en, mem_data_in,
    output mem_data_out
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_address, mem_write_en, mem_read_en, mem_data_in,
    input  mem_data_out
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational byte-lane steering for big-endian sub-word
//            accesses. Extracts and extends a load value from a memory word
//            and merges store data into the old word for read-modify-write.
// Ports    : i_word       - word read from memory (old word for stores)
//            i_offset     - byte offset within the word (addr[1:0])
//            i_size       - access size encoding (3 behaves as word)
//            i_signed     - 1 = sign-extend byte/half loads
//            i_wdata      - right-justified store data
//            o_load_value - extended load result
//            o_store_word - word to write back to memory
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  wire logic [31:0] i_word,
  input  wire logic [1:0]  i_offset,
  input  wire logic [1:0]  i_size,
  input  wire logic        i_signed,
  input  wire logic [31:0] i_wdata,
  output logic      [31:0] o_load_value,
  output logic      [31:0] o_store_word
);

  // Big-endian lanes: byte offset 0 lives in bits [31:24], so the right
  // shift for a byte is 8*(3-offset) = {~offset, 3'b000}; a half at
  // offset 0 lives in bits [31:16].
  logic [4:0]  w_byte_shift;
  logic [4:0]  w_half_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  always_comb begin
    w_byte_shift = {~i_offset, 3'b000};
    w_half_shift = {~i_offset[1], 4'b0000};
    w_byte       = 8'(i_word >> w_byte_shift);
    w_half       = 16'(i_word >> w_half_shift);
    w_byte_mask  = 32'h0000_00FF << w_byte_shift;
    w_half_mask  = 32'h0000_FFFF << w_half_shift;

    o_load_value = i_word;
    o_store_word = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_load_value = {{24{i_signed & w_byte[7]}}, w_byte};
        o_store_word = (i_word & ~w_byte_mask)
                     | ({24'h0, i_wdata[7:0]} << w_byte_shift);
      end
      SIZE_HALF: begin
        o_load_value = {{16{i_signed & w_half[15]}}, w_half};
        o_store_word = (i_word & ~w_half_mask)
                     | ({16'h0, i_wdata[15:0]} << w_half_shift);
      end
      default: begin
        o_load_value = i_word;
        o_store_word = i_wdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into
//            whole-word accesses on a word-addressed data memory. Sub-word
//            stores use read-modify-write; misaligned requests are answered
//            with an error and never touch memory.
// Ports    : clk   - system clock, rising edge
//            reset - synchronous, active-high reset
//            bus   - load_store_unit_if.slave: request handshake
//                    (req_valid/req_ready/req_write/req_size/req_signed/
//                    req_addr/req_wdata), one-cycle response (resp_valid/
//                    resp_rdata/resp_err) and the memory bus (mem_address/
//                    mem_write_en/mem_read_en/mem_data_in/mem_data_out)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32   // only 32 is supported
)(
  input wire logic         clk,
  input wire logic         reset,
  load_store_unit_if.slave bus
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic [31:0]           r_mem_address;
  logic [1:0]            r_offset;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_subword;
  logic [31:0] w_load_value;
  logic [31:0] w_store_word;

  assign w_accept     = bus.req_valid && (r_state == IDLE);
  assign w_misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  // Reserved size 3 is a full word, so only byte and half need RMW.
  assign w_subword    = (bus.req_size == SIZE_BYTE) || (bus.req_size == SIZE_HALF);

  // --------------------------------------------------------------------------
  // State and request latches
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_mem_address <= 32'h0;
      r_offset      <= 2'b00;
      r_size        <= SIZE_BYTE;
      r_signed      <= 1'b0;
      r_write       <= 1'b0;
      r_err         <= 1'b0;
      r_wdata       <= '0;
      r_word        <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mem_address <= 32'(bus.req_addr >> 2);
        r_offset      <= bus.req_addr[1:0];
        r_size        <= bus.req_size;
        r_signed      <= bus.req_signed;
        r_write       <= bus.req_write;
        r_err         <= w_misaligned;
        r_wdata       <= bus.req_wdata;
      end
      // mem_data_out is only meaningful while mem_read_en is high, which is
      // exactly these two states; sampling anywhere else could pick up Z.
      if ((r_state == RD) || (r_state == RMW_RD)) begin
        r_word <= bus.mem_data_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_misaligned)       w_next = RESP;
          else if (!bus.req_write) w_next = RD;
          else if (w_subword)     w_next = RMW_RD;
          else                    w_next = WR;
        end
      end
      RD:      w_next = RESP;
      WR:      w_next = RESP;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Lane steering: the captured word feeds both load extraction (in RESP)
  // and the store merge (in RMW_WR). For word stores the merge simply
  // passes wdata through, so mem_data_in needs no extra mux.
  // --------------------------------------------------------------------------
  lsu_lane_align u_lane_align (
    .i_word       (r_word),
    .i_offset     (r_offset),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_wdata      (r_wdata),
    .o_load_value (w_load_value),
    .o_store_word (w_store_word)
  );

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready    = (r_state == IDLE);
  assign bus.resp_valid   = (r_state == RESP);
  assign bus.resp_err     = (r_state == RESP) && r_err;
  assign bus.resp_rdata   = ((r_state == RESP) && !r_err && !r_write) ? w_load_value : '0;
  assign bus.mem_read_en  = (r_state == RD) || (r_state == RMW_RD);
  assign bus.mem_write_en = (r_state == WR) || (r_state == RMW_WR);
  assign bus.mem_address  = r_mem_address;
  assign bus.mem_data_in  = w_store_word;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. Directed requests push
//            their expected response onto a scoreboard queue; a monitor pops
//            and compares on every resp_valid, including latency and the
//            number of memory strobes seen for that transaction.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          rd;
    int          wr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];

  int rd_cnt = 0;
  int wr_cnt = 0;
  int tot_wr = 0;
  int last_wr_cyc = -1;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed memory model. A poison value stands in for high-Z when
  // the read enable is low so any stray capture shows up in the data.
  logic [31:0] mem [0:15] = '{1: 32'h1122_3344, 2: 32'hA5A5_A5A5, default: 32'h0};

  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_address[3:0]] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = bus.mem_read_en ? mem[bus.mem_address[3:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (bus.mem_read_en) rd_cnt++;
      if (bus.mem_write_en) begin
        wr_cnt++;
        tot_wr++;
        last_wr_cyc = cyc;
      end
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(e.err));
          chk("resp_latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("read_strobes", 32'(rd_cnt), 32'(e.rd));
          chk("write_strobes", 32'(wr_cnt), 32'(e.wr));
          if (e.wr > 0) chk("write_cycle", 32'(last_wr_cyc), 32'(e.cyc - 1));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Issue one request at a negedge once req_ready is seen; the acceptance
  // cycle is the cycle in which valid and ready are both high.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input int erd, input int ewr, input bit push);
    int   k;
    exp_t e;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (k == 20) chk("req_ready_timeout", 32'd0, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      e.rd    = erd;
      e.wr    = ewr;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h5A5A_5A5A;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0) return;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                      input logic [31:0] exp_rdata);
    issue(1'b0, sz, sg, addr, 32'h0, exp_rdata, 1'b0, 2, 1, 0, 1'b1);
  endtask

  initial begin
    logic [31:0] saved0, saved1;
    int          wr_before;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = SIZE_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_we_re", {30'h0, bus.mem_write_en, bus.mem_read_en}, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_data_in", bus.mem_data_in, 32'h0);
    reset = 1'b0;

    // Word store then loads of every flavour
    issue(1'b1, SIZE_WORD, 1'b0, 32'h0, 32'h80FF_1234, 32'h0, 1'b0, 2, 0, 1, 1'b1);
    drain();
    chk("sw_word0", mem[0], 32'h80FF_1234);

    load(SIZE_BYTE, 1'b1, 32'h0, 32'hFFFF_FF80);   // lb
    load(SIZE_BYTE, 1'b0, 32'h0, 32'h0000_0080);   // lbu
    load(SIZE_HALF, 1'b1, 32'h0, 32'hFFFF_80FF);   // lh
    load(SIZE_HALF, 1'b0, 32'h2, 32'h0000_1234);   // lhu
    load(SIZE_WORD, 1'b0, 32'h0, 32'h80FF_1234);   // lw
    load(SIZE_BYTE, 1'b1, 32'h1, 32'hFFFF_FFFF);   // lb lane 1
    load(SIZE_BYTE, 1'b0, 32'h3, 32'h0000_0034);   // lbu lane 3
    load(SIZE_HALF, 1'b1, 32'h2, 32'h0000_1234);   // lh positive
    load(2'd3,      1'b1, 32'h0, 32'h80FF_1234);   // reserved size = word
    load(SIZE_WORD, 1'b1, 32'h8, 32'hA5A5_A5A5);   // lw ignores signed
    drain();

    // Sub-word stores via read-modify-write
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h1, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 1, 1'b1);
    drain();
    chk("sb_word0", mem[0], 32'h80AB_1234);
    issue(1'b1, SIZE_HALF, 1'b0, 32'h6, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 1, 1'b1);
    drain();
    chk("sh_word1", mem[1], 32'h1122_BEEF);
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h3, 32'h1234_5677, 32'h0, 1'b0, 3, 1, 1, 1'b1);
    drain();
    chk("sb_upper_bits_ignored", mem[0], 32'h80AB_1277);
    load(SIZE_HALF, 1'b0, 32'h4, 32'h0000_1122);
    load(SIZE_HALF, 1'b1, 32'h6, 32'hFFFF_BEEF);
    drain();

    // Misaligned requests: error after one cycle, no strobes, memory intact
    saved0 = mem[0];
    saved1 = mem[1];
    issue(1'b0, SIZE_WORD, 1'b0, 32'h2, 32'h0,         32'h0, 1'b1, 1, 0, 0, 1'b1);
    issue(1'b1, SIZE_HALF, 1'b0, 32'h3, 32'h0000_CAFE, 32'h0, 1'b1, 1, 0, 0, 1'b1);
    issue(1'b1, SIZE_WORD, 1'b0, 32'h5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 0, 1'b1);
    issue(1'b0, SIZE_HALF, 1'b1, 32'h1, 32'h0,         32'h0, 1'b1, 1, 0, 0, 1'b1);
    drain();
    chk("misaligned_word0_unchanged", mem[0], saved0);
    chk("misaligned_word1_unchanged", mem[1], saved1);

    // Reset during RMW_RD aborts the byte store with no write and no response
    saved0    = mem[0];
    wr_before = tot_wr;
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h0, 32'h0000_00CC, 32'h0, 1'b0, 3, 1, 1, 1'b0);
    chk("abort_in_rmw_rd", 32'(bus.mem_read_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("abort_no_write", 32'(tot_wr), 32'(wr_before));
    chk("abort_word0_unchanged", mem[0], saved0);

    // Unit is usable again after the abort
    load(SIZE_WORD, 1'b0, 32'h0, saved0);
    drain();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
